// File: rtl/axi_mem_responder.sv
// AXI4 slave over a word-addressed on-chip RAM with independent read and write
// engines, one outstanding INCR burst each, DECERR/SLVERR reporting.
module axi_mem_responder #(
  parameter int C_ADDR_WIDTH     = 64,
  parameter int C_DATA_WIDTH     = 32,
  parameter int C_ID_WIDTH       = 1,
  parameter int C_MEM_DEPTH_LOG2 = 10
) (
  input  logic                      ap_clk,
  input  logic                      areset,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [C_ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [C_ID_WIDTH-1:0]     s_awid,
  input  logic [7:0]                s_awlen,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  input  logic [C_DATA_WIDTH-1:0]   s_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                      s_wlast,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  output logic [C_ID_WIDTH-1:0]     s_bid,
  output logic [1:0]                s_bresp,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  input  logic [C_ADDR_WIDTH-1:0]   s_araddr,
  input  logic [C_ID_WIDTH-1:0]     s_arid,
  input  logic [7:0]                s_arlen,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic [C_DATA_WIDTH-1:0]   s_rdata,
  output logic [C_ID_WIDTH-1:0]     s_rid,
  output logic [1:0]                s_rresp,
  output logic                      s_rlast
);
  localparam int NB    = C_DATA_WIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int IW    = C_MEM_DEPTH_LOG2;
  localparam int DEPTH = 1 << C_MEM_DEPTH_LOG2;
  localparam logic [C_ADDR_WIDTH-1:0] BEAT_BYTES = C_ADDR_WIDTH'(NB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  function automatic logic out_of_range(input logic [C_ADDR_WIDTH-1:0] a);
    return (a >> (C_MEM_DEPTH_LOG2 + LB)) != '0;
  endfunction

  function automatic logic [IW-1:0] ram_idx(input logic [C_ADDR_WIDTH-1:0] a);
    return IW'(a >> LB);
  endfunction

  wstate_t                 r_wstate, w_wstate_nxt;
  logic [C_ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]              r_wlen, r_wbeat;
  logic [C_ID_WIDTH-1:0]   r_wid;
  logic                    r_wdec, r_wslv;
  rstate_t                 r_rstate, w_rstate_nxt;
  logic [C_ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]              r_rlen, r_rbeat;
  logic [C_ID_WIDTH-1:0]   r_rid;
  logic [C_DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [C_DATA_WIDTH-1:0] r_rdbuf;

  logic w_aw_hs, w_w_hs, w_w_oob, w_wlast_beat, w_mem_we;
  logic w_ar_hs, w_r_hs, w_r_oob, w_rlast_beat, w_rd_en;
  logic [IW-1:0] w_wr_idx, w_rd_idx;

  assign w_aw_hs      = s_awvalid & s_awready;
  assign w_w_hs       = s_wvalid & s_wready;
  assign w_w_oob      = out_of_range(r_waddr);
  assign w_wlast_beat = (r_wbeat == r_wlen);
  assign w_mem_we     = w_w_hs & ~w_w_oob;
  assign w_wr_idx     = ram_idx(r_waddr);

  assign w_ar_hs      = s_arvalid & s_arready;
  assign w_r_hs       = s_rvalid & s_rready;
  assign w_r_oob      = out_of_range(r_raddr);
  assign w_rlast_beat = (r_rbeat == r_rlen);
  // The read register only advances on fetch or handshake, so R outputs hold while stalled.
  assign w_rd_en      = (r_rstate == R_FETCH) | w_r_hs;
  assign w_rd_idx     = w_r_hs ? ram_idx(r_raddr + BEAT_BYTES) : ram_idx(r_raddr);

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      r_wstate <= W_IDLE;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wbeat  <= '0;
      r_wid    <= '0;
      r_wdec   <= 1'b0;
      r_wslv   <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_waddr <= s_awaddr;
        r_wlen  <= s_awlen;
        r_wid   <= s_awid;
        r_wbeat <= '0;
        r_wdec  <= 1'b0;
        r_wslv  <= 1'b0;
      end else if (w_w_hs) begin
        r_waddr <= r_waddr + BEAT_BYTES;
        r_wbeat <= r_wbeat + 8'd1;
        if (w_w_oob) r_wdec <= 1'b1;
        if (s_wlast != w_wlast_beat) r_wslv <= 1'b1;
      end
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    s_awready    = 1'b0;
    s_wready     = 1'b0;
    s_bvalid     = 1'b0;
    s_bid        = '0;
    s_bresp      = RESP_OKAY;
    case (r_wstate)
      W_IDLE: begin
        s_awready = ~areset;
        if (s_awvalid && !areset) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid && w_wlast_beat) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        s_bid    = r_wid;
        s_bresp  = r_wdec ? RESP_DECERR : (r_wslv ? RESP_SLVERR : RESP_OKAY);
        if (s_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      r_rstate <= R_IDLE;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rbeat  <= '0;
      r_rid    <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_raddr <= s_araddr;
        r_rlen  <= s_arlen;
        r_rid   <= s_arid;
        r_rbeat <= '0;
      end else if (w_r_hs) begin
        r_raddr <= r_raddr + BEAT_BYTES;
        r_rbeat <= r_rbeat + 8'd1;
      end
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    s_arready    = 1'b0;
    s_rvalid     = 1'b0;
    s_rdata      = '0;
    s_rid        = '0;
    s_rresp      = RESP_OKAY;
    s_rlast      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        s_arready = ~areset;
        if (s_arvalid && !areset) w_rstate_nxt = R_FETCH;
      end
      R_FETCH: w_rstate_nxt = R_DATA;
      R_DATA: begin
        s_rvalid = 1'b1;
        s_rid    = r_rid;
        s_rlast  = w_rlast_beat;
        s_rresp  = w_r_oob ? RESP_DECERR : RESP_OKAY;
        s_rdata  = w_r_oob ? '0 : r_rdbuf;
        if (s_rready && w_rlast_beat) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read-first RAM: a same-cycle write to the word being read is seen on the next fetch.
  always_ff @(posedge ap_clk) begin
    if (w_rd_en) r_rdbuf <= r_mem[w_rd_idx];
    if (w_mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (s_wstrb[b]) r_mem[w_wr_idx][b*8 +: 8] <= s_wdata[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized bench for axi_mem_responder: byte-level memory model, write/read
// drivers with random backpressure, per-scenario checks.
module tb_axi_mem_responder;
  localparam int AW    = 64;
  localparam int DW    = 32;
  localparam int IDW   = 1;
  localparam int WORDS = 1024;

  logic           ap_clk = 1'b0;
  logic           areset = 1'b0;
  logic           s_awvalid = 1'b0, s_awready;
  logic [AW-1:0]  s_awaddr = '0;
  logic [IDW-1:0] s_awid = '0;
  logic [7:0]     s_awlen = '0;
  logic           s_wvalid = 1'b0, s_wready;
  logic [DW-1:0]  s_wdata = '0;
  logic [3:0]     s_wstrb = '0;
  logic           s_wlast = 1'b0;
  logic           s_bvalid, s_bready = 1'b0;
  logic [IDW-1:0] s_bid;
  logic [1:0]     s_bresp;
  logic           s_arvalid = 1'b0, s_arready;
  logic [AW-1:0]  s_araddr = '0;
  logic [IDW-1:0] s_arid = '0;
  logic [7:0]     s_arlen = '0;
  logic           s_rvalid, s_rready = 1'b0;
  logic [DW-1:0]  s_rdata;
  logic [IDW-1:0] s_rid;
  logic [1:0]     s_rresp;
  logic           s_rlast;

  always #5 ap_clk = ~ap_clk;

  axi_mem_responder #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_ID_WIDTH(IDW), .C_MEM_DEPTH_LOG2(10)) dut (
    .ap_clk(ap_clk), .areset(areset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp),
    .s_rlast(s_rlast)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]    mem_model [WORDS];
  logic [31:0]    tb_wdata [256];
  logic [3:0]     tb_wstrb [256];
  logic [31:0]    ob_data [256];
  logic [1:0]     ob_resp [256];
  logic           ob_last [256];
  logic [IDW-1:0] ob_id [256];
  int             ob_cyc [256];
  int             ob_n, ob_first, ob_unstable, ob_timeout;
  logic [1:0]     wb_resp;
  logic [IDW-1:0] wb_id;
  int             wb_wait, wb_unstable, wb_timeout;

  // Reference: a burst is a list of byte addresses A+4k; in-range words take strobed bytes.
  function automatic logic [1:0] model_write(input logic [63:0] addr, input int len, input int wlast_at);
    logic        dec;
    logic [63:0] a;
    dec = 1'b0;
    for (int k = 0; k <= len; k++) begin
      a = addr + 64'(k * 4);
      if (a < 64'(WORDS * 4)) begin
        for (int b = 0; b < 4; b++)
          if (tb_wstrb[k][b]) mem_model[int'(a >> 2)][b*8 +: 8] = tb_wdata[k][b*8 +: 8];
      end else dec = 1'b1;
    end
    if (dec) return 2'b11;
    if (wlast_at != len) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [63:0] addr, input int k);
    logic [63:0] a;
    a = addr + 64'(k * 4);
    return (a < 64'(WORDS * 4)) ? mem_model[int'(a >> 2)] : 32'h0;
  endfunction

  function automatic logic [1:0] model_rresp(input logic [63:0] addr, input int k);
    logic [63:0] a;
    a = addr + 64'(k * 4);
    return (a < 64'(WORDS * 4)) ? 2'b00 : 2'b11;
  endfunction

  task automatic axi_write(input logic [63:0] addr, input int len, input logic [IDW-1:0] id,
                           input int wlast_at, input int bp);
    int cnt, beat;
    logic v, hs, br, pb, pbr;
    logic [1:0] pbresp;
    logic [IDW-1:0] pbid;
    wb_timeout = 0; wb_unstable = 0; wb_wait = -1; wb_resp = 'x; wb_id = 'x;
    @(negedge ap_clk);
    s_awvalid = 1'b1; s_awaddr = addr; s_awlen = 8'(len); s_awid = id;
    cnt = 0;
    while (!s_awready && cnt < 100) begin @(negedge ap_clk); cnt++; end
    if (!s_awready) wb_timeout = 1;
    @(negedge ap_clk);
    s_awvalid = 1'b0;
    beat = 0; cnt = 0;
    while (beat <= len && cnt < 5000) begin
      v = ($urandom_range(0, 99) >= bp);
      s_wvalid = v; s_wdata = tb_wdata[beat]; s_wstrb = tb_wstrb[beat]; s_wlast = (beat == wlast_at);
      hs = v && s_wready;
      @(negedge ap_clk);
      if (hs) beat++;
      cnt++;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    if (beat <= len) wb_timeout = 1;
    cnt = 0; pb = 1'b0; pbr = 1'b0; pbresp = '0; pbid = '0;
    while (cnt < 5000) begin
      br = ($urandom_range(0, 99) >= bp);
      s_bready = br;
      if (s_bvalid) begin
        if (wb_wait < 0) wb_wait = cnt;
        if (pb && !pbr && (s_bresp !== pbresp || s_bid !== pbid)) wb_unstable++;
        if (br) begin wb_resp = s_bresp; wb_id = s_bid; end
      end
      pb = s_bvalid; pbr = br; pbresp = s_bresp; pbid = s_bid;
      @(negedge ap_clk);
      cnt++;
      if (pb && pbr) break;
    end
    s_bready = 1'b0;
    if (!(pb && pbr)) wb_timeout = 1;
  endtask

  task automatic axi_read(input logic [63:0] addr, input int len, input logic [IDW-1:0] id, input int bp);
    int cnt, c;
    logic rr, pv, pr, plast, done;
    logic [31:0] pdata;
    logic [1:0] presp;
    ob_n = 0; ob_first = -1; ob_unstable = 0; ob_timeout = 0;
    @(negedge ap_clk);
    s_arvalid = 1'b1; s_araddr = addr; s_arlen = 8'(len); s_arid = id;
    cnt = 0;
    while (!s_arready && cnt < 100) begin @(negedge ap_clk); cnt++; end
    if (!s_arready) ob_timeout = 1;
    @(negedge ap_clk);
    s_arvalid = 1'b0;
    c = 1; done = 1'b0; pv = 1'b0; pr = 1'b0; pdata = '0; presp = '0; plast = 1'b0;
    while (!done && c < 20000) begin
      rr = ($urandom_range(0, 99) >= bp);
      s_rready = rr;
      if (s_rvalid) begin
        if (ob_first < 0) ob_first = c;
        if (pv && !pr && (s_rdata !== pdata || s_rresp !== presp || s_rlast !== plast)) ob_unstable++;
        if (rr) begin
          ob_data[ob_n] = s_rdata; ob_resp[ob_n] = s_rresp; ob_last[ob_n] = s_rlast;
          ob_id[ob_n] = s_rid; ob_cyc[ob_n] = c;
          ob_n++;
          if (s_rlast || ob_n == len + 1) done = 1'b1;
        end
      end
      pv = s_rvalid; pr = rr; pdata = s_rdata; presp = s_rresp; plast = s_rlast;
      @(negedge ap_clk);
      c++;
    end
    s_rready = 1'b0;
    if (!done) ob_timeout = 1;
  endtask

  task automatic test_reset();
    #1 areset = 1'b1;
    #1;
    n_cmp++; if (s_awready !== 1'b0) begin n_err++; $display("FAIL reset_awready got=%b exp=0", s_awready); end
    n_cmp++; if (s_arready !== 1'b0) begin n_err++; $display("FAIL reset_arready got=%b exp=0", s_arready); end
    n_cmp++; if (s_wready !== 1'b0) begin n_err++; $display("FAIL reset_wready got=%b exp=0", s_wready); end
    n_cmp++; if (s_bvalid !== 1'b0) begin n_err++; $display("FAIL reset_bvalid got=%b exp=0", s_bvalid); end
    n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got=%b exp=0", s_rvalid); end
    n_cmp++; if (s_rdata !== 32'h0 || s_rresp !== 2'b00 || s_bresp !== 2'b00)
      begin n_err++; $display("FAIL reset_outputs rdata=%h rresp=%b bresp=%b exp=0", s_rdata, s_rresp, s_bresp); end
    repeat (3) @(negedge ap_clk);
    areset = 1'b0;
    #1;
    n_cmp++; if (s_awready !== 1'b1) begin n_err++; $display("FAIL post_reset_awready got=%b exp=1", s_awready); end
    n_cmp++; if (s_arready !== 1'b1) begin n_err++; $display("FAIL post_reset_arready got=%b exp=1", s_arready); end
  endtask

  task automatic test_fill();
    logic [1:0] exp;
    for (int blk = 0; blk < 4; blk++) begin
      for (int k = 0; k < 256; k++) begin tb_wdata[k] = $urandom; tb_wstrb[k] = 4'hF; end
      exp = model_write(64'(blk * 1024), 255, 255);
      axi_write(64'(blk * 1024), 255, 1'b0, 255, 0);
      n_cmp++; if (wb_timeout != 0 || wb_resp !== exp)
        begin n_err++; $display("FAIL fill_bresp blk=%0d got=%b exp=%b timeout=%0d", blk, wb_resp, exp, wb_timeout); end
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) begin tb_wdata[k] = 32'(k + 1); tb_wstrb[k] = 4'hF; end
    void'(model_write(64'h0, 3, 3));
    axi_write(64'h0, 3, 1'b0, 3, 0);
    n_cmp++; if (wb_resp !== 2'b00 || wb_timeout != 0)
      begin n_err++; $display("FAIL basic_bresp got=%b exp=00 timeout=%0d", wb_resp, wb_timeout); end
    n_cmp++; if (wb_id !== 1'b0) begin n_err++; $display("FAIL basic_bid got=%b exp=0", wb_id); end
    n_cmp++; if (wb_wait != 0) begin n_err++; $display("FAIL basic_bvalid_latency got=%0d exp=0", wb_wait); end
    axi_read(64'h0, 3, 1'b0, 0);
    n_cmp++; if (ob_n != 4 || ob_timeout != 0)
      begin n_err++; $display("FAIL basic_rbeats got=%0d exp=4 timeout=%0d", ob_n, ob_timeout); end
    n_cmp++; if (ob_first != 2) begin n_err++; $display("FAIL basic_rvalid_latency got=%0d exp=2", ob_first); end
    for (int k = 0; k < ob_n; k++) begin
      n_cmp++;
      if (ob_data[k] !== 32'(k + 1) || ob_resp[k] !== 2'b00 || ob_last[k] !== (k == 3) || ob_cyc[k] != 2 + k)
        begin n_err++; $display("FAIL basic_rbeat%0d got=%h/%b/%b/c%0d exp=%h/00/%b/c%0d", k, ob_data[k],
          ob_resp[k], ob_last[k], ob_cyc[k], k + 1, (k == 3), 2 + k); end
    end
  endtask

  task automatic test_strobe();
    tb_wdata[0] = 32'hAABBCCDD; tb_wstrb[0] = 4'hF;
    void'(model_write(64'h100, 0, 0));
    axi_write(64'h100, 0, 1'b0, 0, 0);
    tb_wdata[0] = 32'h11223344; tb_wstrb[0] = 4'h5;
    void'(model_write(64'h100, 0, 0));
    axi_write(64'h100, 0, 1'b1, 0, 0);
    n_cmp++; if (wb_resp !== 2'b00 || wb_id !== 1'b1)
      begin n_err++; $display("FAIL strobe_b got=%b/%b exp=00/1", wb_resp, wb_id); end
    axi_read(64'h100, 0, 1'b0, 0);
    n_cmp++; if (ob_n != 1 || ob_data[0] !== 32'hAA22CC44 || ob_last[0] !== 1'b1)
      begin n_err++; $display("FAIL strobe_rdata got=%h last=%b n=%0d exp=aa22cc44 last=1", ob_data[0], ob_last[0], ob_n); end
  endtask

  task automatic test_boundary();
    logic [31:0] d0;
    d0 = $urandom;
    tb_wdata[0] = d0; tb_wstrb[0] = 4'hF; tb_wdata[1] = $urandom; tb_wstrb[1] = 4'hF;
    void'(model_write(64'hFFC, 1, 1));
    axi_write(64'hFFC, 1, 1'b1, 1, 0);
    n_cmp++; if (wb_resp !== 2'b11 || wb_id !== 1'b1)
      begin n_err++; $display("FAIL boundary_b got=%b/%b exp=11/1", wb_resp, wb_id); end
    axi_read(64'hFFC, 1, 1'b1, 0);
    n_cmp++; if (ob_n != 2 || ob_data[0] !== d0 || ob_resp[0] !== 2'b00 || ob_id[0] !== 1'b1)
      begin n_err++; $display("FAIL boundary_beat0 got=%h/%b id=%b exp=%h/00 id=1", ob_data[0], ob_resp[0], ob_id[0], d0); end
    n_cmp++; if (ob_data[1] !== 32'h0 || ob_resp[1] !== 2'b11 || ob_last[1] !== 1'b1)
      begin n_err++; $display("FAIL boundary_beat1 got=%h/%b/%b exp=0/11/1", ob_data[1], ob_resp[1], ob_last[1]); end
  endtask

  task automatic test_slverr();
    int wl;
    for (int t = 0; t < 2; t++) begin
      wl = (t == 0) ? 1 : -1;
      for (int k = 0; k < 4; k++) begin tb_wdata[k] = $urandom; tb_wstrb[k] = 4'hF; end
      void'(model_write(64'h40, 3, wl));
      axi_write(64'h40, 3, 1'b1, wl, 0);
      n_cmp++; if (wb_resp !== 2'b10 || wb_id !== 1'b1 || wb_timeout != 0)
        begin n_err++; $display("FAIL slverr_b wlast_at=%0d got=%b/%b exp=10/1", wl, wb_resp, wb_id); end
      axi_read(64'h40, 3, 1'b0, 0);
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (ob_data[k] !== model_rdata(64'h40, k))
          begin n_err++; $display("FAIL slverr_data beat=%0d got=%h exp=%h", k, ob_data[k], model_rdata(64'h40, k)); end
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] addr;
    int len, bp, bad;
    logic [IDW-1:0] id;
    logic [1:0] exp;
    for (int it = 0; it < 6; it++) begin
      case (it)
        0, 1:    begin addr = 64'($urandom_range(0, 767)) * 4; len = 255; end
        2:       begin addr = 64'($urandom_range(900, 1023)) * 4; len = 255; end
        3:       begin addr = 64'($urandom_range(0, 1023)) * 4; len = 0; end
        default: begin addr = 64'($urandom_range(0, 1100)) * 4; len = $urandom_range(1, 255); end
      endcase
      bp = $urandom_range(20, 50);
      id = IDW'($urandom);
      for (int k = 0; k <= len; k++) begin tb_wdata[k] = $urandom; tb_wstrb[k] = 4'($urandom); end
      exp = model_write(addr, len, len);
      axi_write(addr, len, id, len, bp);
      n_cmp++; if (wb_timeout != 0 || wb_resp !== exp || wb_id !== id)
        begin n_err++; $display("FAIL rand_b it=%0d got=%b/%b exp=%b/%b timeout=%0d", it, wb_resp, wb_id, exp, id, wb_timeout); end
      n_cmp++; if (wb_unstable != 0 || wb_wait != 0)
        begin n_err++; $display("FAIL rand_b_hold it=%0d unstable=%0d wait=%0d exp=0/0", it, wb_unstable, wb_wait); end
      axi_read(addr, len, ~id, bp);
      n_cmp++; if (ob_timeout != 0 || ob_n != len + 1 || ob_first != 2)
        begin n_err++; $display("FAIL rand_r_count it=%0d got=%0d first=%0d exp=%0d first=2", it, ob_n, ob_first, len + 1); end
      n_cmp++; if (ob_unstable != 0)
        begin n_err++; $display("FAIL rand_r_hold it=%0d unstable=%0d exp=0", it, ob_unstable); end
      bad = 0;
      for (int k = 0; k < ob_n; k++) begin
        n_cmp++;
        if (ob_data[k] !== model_rdata(addr, k) || ob_resp[k] !== model_rresp(addr, k) ||
            ob_last[k] !== (k == len) || ob_id[k] !== ~id) begin
          n_err++;
          if (bad < 4) $display("FAIL rand_rbeat it=%0d beat=%0d got=%h/%b/%b exp=%h/%b/%b", it, k, ob_data[k],
            ob_resp[k], ob_last[k], model_rdata(addr, k), model_rresp(addr, k), (k == len));
          bad++;
        end
      end
    end
  endtask

  task automatic test_concurrent();
    for (int k = 0; k < 64; k++) begin tb_wdata[k] = $urandom; tb_wstrb[k] = 4'hF; end
    void'(model_write(64'h0, 63, 63));
    fork
      axi_write(64'h0, 63, 1'b0, 63, 25);
      axi_read(64'h800, 63, 1'b1, 25);
    join
    n_cmp++; if (wb_resp !== 2'b00 || wb_timeout != 0)
      begin n_err++; $display("FAIL conc_bresp got=%b exp=00 timeout=%0d", wb_resp, wb_timeout); end
    n_cmp++; if (ob_n != 64 || ob_timeout != 0) begin n_err++; $display("FAIL conc_rbeats got=%0d exp=64", ob_n); end
    for (int k = 0; k < ob_n; k++) begin
      n_cmp++; if (ob_data[k] !== model_rdata(64'h800, k))
        begin n_err++; $display("FAIL conc_rdata beat=%0d got=%h exp=%h", k, ob_data[k], model_rdata(64'h800, k)); end
    end
    axi_read(64'h0, 63, 1'b0, 0);
    for (int k = 0; k < ob_n; k++) begin
      n_cmp++; if (ob_data[k] !== model_rdata(64'h0, k))
        begin n_err++; $display("FAIL conc_wdata beat=%0d got=%h exp=%h", k, ob_data[k], model_rdata(64'h0, k)); end
    end
  endtask

  task automatic test_reset_mid_read();
    int cnt;
    @(negedge ap_clk);
    s_arvalid = 1'b1; s_araddr = 64'h200; s_arlen = 8'd63; s_arid = 1'b0;
    cnt = 0;
    while (!s_arready && cnt < 100) begin @(negedge ap_clk); cnt++; end
    @(negedge ap_clk);
    s_arvalid = 1'b0; s_rready = 1'b1;
    cnt = 0;
    while (!s_rvalid && cnt < 10) begin @(negedge ap_clk); cnt++; end
    n_cmp++; if (s_rvalid !== 1'b1) begin n_err++; $display("FAIL midrst_burst_started got=%b exp=1", s_rvalid); end
    repeat (3) @(negedge ap_clk);
    areset = 1'b1;
    #1;
    n_cmp++; if (s_rvalid !== 1'b0 || s_rlast !== 1'b0 || s_rdata !== 32'h0)
      begin n_err++; $display("FAIL midrst_rvalid got=%b/%b/%h exp=0/0/0", s_rvalid, s_rlast, s_rdata); end
    n_cmp++; if (s_arready !== 1'b0 || s_awready !== 1'b0)
      begin n_err++; $display("FAIL midrst_ready got=%b/%b exp=0/0", s_arready, s_awready); end
    repeat (2) @(negedge ap_clk);
    areset = 1'b0; s_rready = 1'b0;
    #1;
    n_cmp++; if (s_arready !== 1'b1 || s_rvalid !== 1'b0)
      begin n_err++; $display("FAIL midrst_release got=%b/%b exp=1/0", s_arready, s_rvalid); end
    axi_read(64'h200, 15, 1'b1, 0);
    n_cmp++; if (ob_n != 16 || ob_first != 2 || ob_timeout != 0)
      begin n_err++; $display("FAIL midrst_reread got=%0d first=%0d exp=16 first=2", ob_n, ob_first); end
    for (int k = 0; k < ob_n; k++) begin
      n_cmp++; if (ob_data[k] !== model_rdata(64'h200, k) || ob_id[k] !== 1'b1)
        begin n_err++; $display("FAIL midrst_rdata beat=%0d got=%h exp=%h", k, ob_data[k], model_rdata(64'h200, k)); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_strobe();
    test_boundary();
    test_slverr();
    test_random();
    test_concurrent();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
